uart_rx_ctrl: RTL and testbench

Sequencing controller for the UART receive path. It synchronizes the serial rx line and detects start bits. It times mid-bit sampling and drives the enable and serial input of an external shreg instance. When the stop bit is valid, it latches the shreg parallel output into a holding register and pulses a valid strobe. It sits between the rx pin and the FIR input interface.

---
 rtl/uart_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer. Synchronizes rx, qualifies the start
// bit at mid-bit, strobes an external shift register once per data bit, checks
// the stop bit and publishes the shifted byte with a one-cycle valid strobe.
// Optional build macro UART_RX_PARITY_EN inserts an even-parity bit after DATA.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] sh_out,
  output logic                 sh_en,
  output logic                 sh_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_PARITY
  } state_t;
  localparam state_t AFTER_DATA = S_PARITY;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic          rx_m, rx_s;
  logic          stop_ok;

  // two-flop synchronizer, preset to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign sh_in = rx_s;
  assign busy  = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par, par_err;

  // running XOR of every captured data bit, then compared with the parity bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par     <= 1'b0;
      par_err <= 1'b0;
    end else if (state == S_IDLE) begin
      par     <= 1'b0;
      par_err <= 1'b0;
    end else if (state == S_DATA && cnt == CNT_LAST) begin
      par <= par ^ rx_s;
    end else if (state == S_PARITY && cnt == CNT_LAST) begin
      par_err <= par ^ rx_s;
    end
  end

  assign stop_ok = rx_s & ~par_err;
`else
  assign stop_ok = rx_s;
`endif

  // frame sequencer; strobes are registered so they last exactly one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      sh_en     <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      sh_en     <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          // raised one count early so the pulse sits on the CNT_LAST cycle
          if (cnt == CNT_PRE) sh_en <= 1'b1;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= AFTER_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (stop_ok) begin
              data  <= sh_out;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            // a low stop bit means the line may be held in break
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table of directed frames, hand sequences for glitch,
// break, async reset and parity, then random frames checked against a
// frame-level timing/data model.
module tb_uart_rx_ctrl;
  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // cycles from rx falling edge to valid/frame_err
  localparam int LAT = CPB/2 + (DB+1+PB)*CPB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic [DB-1:0] sh_out;
  logic          sh_en, sh_in, valid, frame_err, busy;
  logic [DB-1:0] data;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .sh_out(sh_out), .sh_en(sh_en),
    .sh_in(sh_in), .data(data), .valid(valid), .frame_err(frame_err),
    .busy(busy)
  );

  // attached shreg: serial in at the top, first bit ends in bit 0
  logic [DB-1:0] sh_reg = '0;
  always @(posedge clk) if (sh_en) sh_reg <= {sh_in, sh_reg[DB-1:1]};
  assign sh_out = sh_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {int cyc; bit ok; logic [7:0] d;} ev_t;
  ev_t ev_q[$];
  int  sh_q[$];
  bit  mon_en = 1'b0;
  int  n_valid = 0, n_err = 0, last_vcyc = 0, prev_vcyc = 0;
  logic [7:0] last_good = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // checks every sh_en / strobe against the expectations queued by send_frame
  always @(negedge clk) begin : mon
    ev_t e;
    int  s;
    if (mon_en) begin
      if (valid && frame_err) chk("valid_and_err_same_cycle", 1, 0);
      if (sh_en) begin
        chk("sh_en_expected", sh_q.size() > 0, 1);
        if (sh_q.size() > 0) begin
          s = sh_q.pop_front();
          chk("sh_en_cycle", cyc, s);
        end
      end
      if (valid || frame_err) begin
        if (valid) begin
          n_valid++;
          prev_vcyc = last_vcyc;
          last_vcyc = cyc;
        end else n_err++;
        chk("strobe_expected", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_is_valid", valid, e.ok);
          chk("strobe_data", data, e.d);
        end
      end
    end
  end

  // drive one frame starting now and queue what the model expects from it
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_good, input int hold);
    int  e0;
    bit  ok;
    ev_t ev;
    e0 = cyc;
    ok = stop && (par_good || PB == 0);
    for (int i = 0; i < DB; i++) sh_q.push_back(e0 + LAT - 1 - CPB*(DB + PB - i));
    ev.cyc = e0 + LAT;
    ev.ok  = ok;
    ev.d   = ok ? d : last_good;
    ev_q.push_back(ev);
    if (ok) last_good = d;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < DB; i++) begin rx = d[i]; tick(CPB); end
    if (PB != 0) begin rx = (^d) ^ ~par_good; tick(CPB); end
    rx = stop; tick(CPB);
    if (!stop) tick(hold);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d; bit stop; int gap; int hold; bit chk_b2b;
    bit exp_valid; logic [7:0] exp_data;
  } row_t;
  row_t tbl[8];

  initial begin
    int nv, ne, w, gap, hold;
    bit stop, pg, prev_err;
    logic [7:0] d;

    tbl = '{
      '{8'hA5, 1'b1, 5, 0,  1'b0, 1'b1, 8'hA5},
      '{8'h3C, 1'b1, 0, 0,  1'b0, 1'b1, 8'h3C},
      '{8'hFF, 1'b1, 0, 0,  1'b1, 1'b1, 8'hFF},
      '{8'h55, 1'b0, 0, 40, 1'b0, 1'b0, 8'hFF},
      '{8'h12, 1'b1, 3, 0,  1'b0, 1'b1, 8'h12},
      '{8'h00, 1'b1, 2, 0,  1'b0, 1'b1, 8'h00},
      '{8'h80, 1'b1, 0, 0,  1'b0, 1'b1, 8'h80},
      '{8'h01, 1'b1, 0, 0,  1'b0, 1'b1, 8'h01}
    };

    // reset state
    tick(2);
    chk("rst_valid", valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_sh_en", sh_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);
    chk("rst_sh_in", sh_in, 1);
    rst = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // directed table
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].gap);
      nv = n_valid; ne = n_err;
      send_frame(tbl[i].d, tbl[i].stop, 1'b1, tbl[i].hold);
      chk("tbl_valid_count", n_valid - nv, tbl[i].exp_valid);
      chk("tbl_err_count", n_err - ne, !tbl[i].exp_valid);
      chk("tbl_data", data, tbl[i].exp_data);
      if (tbl[i].chk_b2b) chk("b2b_valid_spacing", last_vcyc - prev_vcyc, CPB*(DB+2+PB));
    end
    tick(4);

    // start-bit glitch: 5 low cycles must not start a frame
    nv = n_valid; ne = n_err;
    rx = 1'b0; tick(5); rx = 1'b1;
    chk("glitch_busy_seen", busy, 1);
    w = 0;
    while (busy && w < 12) begin tick(1); w++; end
    chk("glitch_busy_drop", busy, 0);
    tick(4);
    chk("glitch_no_strobe", (n_valid - nv) + (n_err - ne), 0);

    // async reset after 4 data bits, then a clean frame
    mon_en = 1'b0;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin rx = i[0]; tick(CPB); end
    tick(8);
    #3 rst = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_sh_en", sh_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", data, 0);
    chk("midrst_sh_in", sh_in, 1);
    rx = 1'b1;
    tick(2);
    rst = 1'b1;
    ev_q.delete(); sh_q.delete();
    last_good = '0;
    mon_en = 1'b1;
    tick(3);
    nv = n_valid;
    send_frame(8'h81, 1'b1, 1'b1, 0);
    chk("post_rst_valid_count", n_valid - nv, 1);
    chk("post_rst_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
    tick(3);
    nv = n_valid;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    chk("par_good_valid", n_valid - nv, 1);
    chk("par_good_data", data, 8'h07);
    tick(3);
    ne = n_err;
    send_frame(8'h07, 1'b1, 1'b0, 0);
    chk("par_bad_err", n_err - ne, 1);
    chk("par_bad_data", data, 8'h07);
`endif

    // random frames against the model
    prev_err = 1'b0;
    for (int k = 0; k < 16; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pg   = ($urandom_range(0, 3) != 0);
      hold = stop ? 0 : int'($urandom_range(0, 30));
      gap  = prev_err ? int'($urandom_range(2, 10)) : int'($urandom_range(0, 10));
      tick(gap);
      send_frame(d, stop, pg, hold);
      prev_err = !stop;
    end
    tick(30);
    chk("strobes_all_seen", ev_q.size(), 0);
    chk("sh_en_all_seen", sh_q.size(), 0);
    chk("final_data", data, last_good);
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
